// File: rtl/fifo_read_scheduler.sv
// Round-robin read scheduler: drains a bank of single-clock FIFOs onto one
// valid/ready output stream, tagging each word with the index of its source FIFO.
module fifo_read_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_FIFOS  = 4,
    parameter int unsigned SEL_BITS   = 2,
    parameter int unsigned BURST_MAX  = 4,
    parameter int unsigned BURST_BITS = 3
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic [NUM_FIFOS-1:0]            i_fifo_empty,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] i_fifo_q,
    output logic [NUM_FIFOS-1:0]            o_read_enable,
    output logic [DATA_WIDTH-1:0]           o_out_data,
    output logic [SEL_BITS-1:0]             o_out_source,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic                            o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SEL_BITS-1:0]   r_current;
    logic [SEL_BITS-1:0]   w_current_nxt;
    logic [SEL_BITS-1:0]   r_last_grant;
    logic [SEL_BITS-1:0]   w_last_grant_nxt;
    logic [BURST_BITS-1:0] r_burst_count;
    logic [BURST_BITS-1:0] w_burst_count_nxt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;
    logic [SEL_BITS-1:0]   r_out_source;
    logic [SEL_BITS-1:0]   w_out_source_nxt;
    logic                  r_out_valid;
    logic                  w_out_valid_nxt;

    logic [DATA_WIDTH-1:0] w_q_arr [NUM_FIFOS];
    logic [SEL_BITS-1:0]   w_idx;
    logic [SEL_BITS-1:0]   w_pick;
    logic                  w_found;
    logic                  w_more;

    // Split the flat FIFO q bus into one word per FIFO
    always_comb begin
        for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
            w_q_arr[i] = i_fifo_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first non-empty FIFO after last_grant, wrapping modulo NUM_FIFOS
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            w_idx = SEL_BITS'((32'(r_last_grant) + 32'd1 + k) % NUM_FIFOS);
            if (!w_found && !i_fifo_empty[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Burst continues on the same FIFO only while budget, enable and data all remain
    assign w_more = ((32'(r_burst_count) + 32'd1) < BURST_MAX) && i_enable
                    && !i_fifo_empty[r_current];

    // Next-state and datapath update decisions
    always_comb begin
        w_state_nxt       = r_state;
        w_current_nxt     = r_current;
        w_last_grant_nxt  = r_last_grant;
        w_burst_count_nxt = r_burst_count;
        w_out_data_nxt    = r_out_data;
        w_out_source_nxt  = r_out_source;
        w_out_valid_nxt   = r_out_valid;
        unique case (r_state)
            S_IDLE: begin
                if (i_enable && w_found) begin
                    w_current_nxt     = w_pick;
                    w_burst_count_nxt = '0;
                    w_state_nxt       = S_READ;
                end
            end
            S_READ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_out_data_nxt   = w_q_arr[r_current];
                w_out_source_nxt = r_current;
                w_out_valid_nxt  = 1'b1;
                w_state_nxt      = S_HOLD;
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    w_out_valid_nxt   = 1'b0;
                    w_burst_count_nxt = r_burst_count + BURST_BITS'(1);
                    if (w_more) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_last_grant_nxt = r_current;
                        w_state_nxt      = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_current     <= '0;
            r_last_grant  <= SEL_BITS'(NUM_FIFOS - 1);
            r_burst_count <= '0;
            r_out_data    <= '0;
            r_out_source  <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_current     <= w_current_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_burst_count <= w_burst_count_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_source  <= w_out_source_nxt;
            r_out_valid   <= w_out_valid_nxt;
        end
    end

    // Read strobe decoded from state; gated so an empty FIFO is never popped
    always_comb begin
        o_read_enable = '0;
        if (r_state == S_READ && !i_fifo_empty[r_current]) begin
            o_read_enable[r_current] = 1'b1;
        end
    end

    assign o_out_data   = r_out_data;
    assign o_out_source = r_out_source;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_read_scheduler.sv
// Scoreboard bench for fifo_read_scheduler: FIFO bank model, transaction-level
// round-robin reference, and a negedge monitor comparing delivered words.
`timescale 1ns/1ps
module tb_fifo_read_scheduler;

    localparam int unsigned DW = 32;
    localparam int unsigned NF = 4;
    localparam int unsigned SB = 2;
    localparam int unsigned BM = 4;
    localparam int unsigned BB = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             out_ready;
    logic [NF-1:0]    fifo_empty = '1;
    logic [NF*DW-1:0] fifo_q = '0;
    logic [NF-1:0]    read_enable;
    logic [DW-1:0]    out_data;
    logic [SB-1:0]    out_source;
    logic             out_valid;
    logic             busy;

    fifo_read_scheduler #(
        .DATA_WIDTH(DW), .NUM_FIFOS(NF), .SEL_BITS(SB), .BURST_MAX(BM), .BURST_BITS(BB)
    ) dut (
        .i_clock      (clock),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_fifo_empty (fifo_empty),
        .i_fifo_q     (fifo_q),
        .o_read_enable(read_enable),
        .o_out_data   (out_data),
        .o_out_source (out_source),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_busy       (busy)
    );

    always #5 clock = ~clock;

    // FIFO bank: registered q, one push port driven by the stimulus process
    logic [DW-1:0] fmem [NF][$];
    logic          push_en = 1'b0;
    int            push_idx = 0;
    logic [DW-1:0] push_dat = '0;
    int            n_reads = 0;

    always @(posedge clock) begin
        for (int i = 0; i < NF; i++) begin
            if (read_enable[i] && fmem[i].size() > 0) begin
                fifo_q[i*DW +: DW] <= fmem[i].pop_front();
                n_reads <= n_reads + 1;
            end
        end
        if (push_en) fmem[push_idx].push_back(push_dat);
        for (int i = 0; i < NF; i++) fifo_empty[i] <= (fmem[i].size() == 0);
    end

    // Reference state: model FIFO contents, last grant, expected {source, data}
    logic [DW-1:0]    mq [NF][$];
    int               m_last;
    logic [SB+DW-1:0] exp_q [$];
    logic [SB+DW-1:0] m_e;
    int               n_vec = 0;
    int               n_err = 0;

    // Monitor: scoreboard compare on handshake, HOLD stability, read strobe legality
    logic          p_valid = 1'b0;
    logic          p_acc   = 1'b0;
    logic [DW-1:0] p_data  = '0;
    logic [SB-1:0] p_src   = '0;

    always @(negedge clock) begin
        if (reset) begin
            p_valid = 1'b0;
            p_acc   = 1'b0;
        end else begin
            if (p_valid && !p_acc) begin
                n_vec++;
                if (!out_valid || out_data != p_data || out_source != p_src) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%0b src=%0d data=%h, required v=1 src=%0d data=%h",
                             out_valid, out_source, out_data, p_src, p_data);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got src=%0d data=%h, required no word", out_source, out_data);
                end else begin
                    m_e = exp_q.pop_front();
                    if ({out_source, out_data} != m_e) begin
                        n_err++;
                        $display("FAIL word: got src=%0d data=%h, required src=%0d data=%h",
                                 out_source, out_data, m_e[SB+DW-1:DW], m_e[DW-1:0]);
                    end
                end
            end
            if (read_enable != '0) begin
                n_vec++;
                if (!$onehot(read_enable) || (read_enable & fifo_empty) != '0) begin
                    n_err++;
                    $display("FAIL read_strobe: got re=%b empty=%b, required one-hot to non-empty",
                             read_enable, fifo_empty);
                end
            end
            p_valid = out_valid;
            p_acc   = out_valid && out_ready;
            p_data  = out_data;
            p_src   = out_source;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int f, input logic [DW-1:0] d);
        push_idx = f;
        push_dat = d;
        push_en  = 1'b1;
        @(posedge clock); #1;
        push_en  = 1'b0;
    endtask

    task automatic load(input int f, input logic [DW-1:0] d);
        push(f, d);
        mq[f].push_back(d);
    endtask

    // Transaction-level round robin: grant next non-empty, take up to BM words, rotate
    task automatic plan_drain();
        int g;
        int c;
        forever begin
            g = -1;
            for (int k = 1; k <= NF; k++) begin
                c = (m_last + k) % NF;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g < 0) break;
            for (int b = 0; b < BM && mq[g].size() > 0; b++) exp_q.push_back({SB'(g), mq[g].pop_front()});
            m_last = g;
        end
    endtask

    task automatic wait_drain(input int budget, input bit rnd);
        int t;
        t = 0;
        while (t < budget && !(exp_q.size() == 0 && !busy && fifo_empty == '1)) begin
            @(posedge clock); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            t++;
        end
        n_vec++;
        if (t >= budget) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_evt(input string name, input int budget, input bit want_re);
        int t;
        t = 0;
        while (t < budget && !(want_re ? (read_enable != '0) : out_valid)) begin
            @(negedge clock);
            t++;
        end
        n_vec++;
        if (t >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: got no event in %0d cycles, required event", name, t);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; m_last = NF - 1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_read_enable", 64'(read_enable), 64'd0);
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_out_data",    64'(out_data),    64'd0);
        chk("rst_out_source",  64'(out_source),  64'd0);
        chk("rst_busy",        64'(busy),        64'd0);

        // Single word from FIFO 0, latency from reset release
        load(0, 32'hA0);
        plan_drain();
        enable = 1'b1; out_ready = 1'b1; reset = 1'b0;
        @(negedge clock); chk("t1_c0_busy", 64'(busy), 64'd0);
        @(negedge clock); chk("t1_c1_read_enable", 64'(read_enable), 64'b0001);
        @(negedge clock); chk("t1_c2_read_enable", 64'(read_enable), 64'd0);
        chk("t1_c2_valid", 64'(out_valid), 64'd0);
        @(negedge clock); chk("t1_c3_valid", 64'(out_valid), 64'd1);
        chk("t1_c3_data", 64'(out_data), 64'hA0);
        chk("t1_c3_source", 64'(out_source), 64'd0);
        wait_drain(50, 1'b0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Burst limit: F1 x6, F2 x2 -> 1,1,1,1,2,2,1,1
        @(posedge clock); #1; enable = 1'b0;
        for (int j = 0; j < 6; j++) load(1, 32'h100 + 32'(j));
        for (int j = 0; j < 2; j++) load(2, 32'h200 + 32'(j));
        plan_drain();
        enable = 1'b1;
        wait_drain(200, 1'b0);

        // Fresh reset, one word per FIFO, then refill F0 to check wrap
        reset = 1'b1; enable = 1'b0; m_last = NF - 1;
        repeat (2) @(posedge clock);
        #1; reset = 1'b0;
        for (int f = 0; f < NF; f++) load(f, 32'h300 + 32'(f));
        plan_drain();
        enable = 1'b1;
        wait_drain(200, 1'b0);
        enable = 1'b0;
        load(0, 32'h3F0);
        plan_drain();
        enable = 1'b1;
        wait_drain(100, 1'b0);

        // Backpressure: 10 cycles of out_ready=0 in HOLD
        enable = 1'b0; out_ready = 1'b0;
        load(2, 32'h4A5A);
        plan_drain();
        enable = 1'b1;
        wait_evt("bp_valid", 20, 1'b0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'h4A5A);
            chk("bp_read_enable", 64'(read_enable), 64'd0);
        end
        @(posedge clock); #1; out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock); chk("bp_valid_drop", 64'(out_valid), 64'd0);
        wait_drain(50, 1'b0);

        // Enable dropped during WAIT: one word delivered, two stay queued
        enable = 1'b0;
        push(0, 32'h501); push(0, 32'h502); push(0, 32'h503);
        exp_q.push_back({SB'(0), 32'h501});
        rd0 = n_reads;
        enable = 1'b1;
        wait_evt("en_read", 20, 1'b1);
        @(posedge clock); #1; enable = 1'b0;
        repeat (8) @(negedge clock);
        chk("en_busy", 64'(busy), 64'd0);
        chk("en_reads", 64'(n_reads - rd0), 64'd1);
        chk("en_left", 64'(fmem[0].size()), 64'd2);
        chk("en_delivered", 64'(exp_q.size()), 64'd0);
        mq[0].push_back(32'h502); mq[0].push_back(32'h503);
        m_last = 0;

        // Reset during HOLD discards the word; search restarts at FIFO 0
        @(posedge clock); #1; out_ready = 1'b0;
        push(1, 32'h600);
        enable = 1'b1;
        wait_evt("rst_hold_valid", 20, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("rh_valid", 64'(out_valid), 64'd0);
        chk("rh_read_enable", 64'(read_enable), 64'd0);
        chk("rh_busy", 64'(busy), 64'd0);
        enable = 1'b0; m_last = NF - 1;
        @(posedge clock); #1;
        load(1, 32'h601);
        plan_drain();
        enable = 1'b1; out_ready = 1'b1; reset = 1'b0;
        wait_drain(100, 1'b0);

        // Randomized fills with random backpressure
        for (int it = 0; it < 30; it++) begin
            enable = 1'b0;
            for (int f = 0; f < NF; f++) begin
                int n;
                n = int'($urandom_range(0, 6));
                for (int j = 0; j < n; j++) load(f, $urandom);
            end
            plan_drain();
            enable = 1'b1;
            wait_drain(2000, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_read_scheduler.md
# fifo_read_scheduler

Round-robin read scheduler that drains up to NUM_FIFOS single-clock FIFOs onto one shared output stream with a valid/ready handshake. It drives each FIFO's `read_enable`, captures the FIFO's registered `q`, and presents one word at a time downstream, tagged with its source index. It sits between a bank of FIFO instances and a single consumer, such as a serializer or a packet builder. All FIFOs read on the same `clock` as this block.

## Interface
- `DATA_WIDTH`, 32: width of each FIFO word.
- `NUM_FIFOS`, 4: number of FIFOs served, 2..16.
- `SEL_BITS`, 2: index width, equal to ceil(log2(NUM_FIFOS)).
- `BURST_MAX`, 4: maximum words taken from one FIFO per grant before rotating, ≥1.
- `BURST_BITS`, 3: counter width, able to hold BURST_MAX.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  scheduler enable.
- `fifo_empty`  in  NUM_FIFOS  bit i is `fifo_empty` of FIFO i.
- `fifo_q`  in  NUM_FIFOS*DATA_WIDTH  FIFO i `q` on bits [i*DATA_WIDTH +: DATA_WIDTH].
- `read_enable`  out  NUM_FIFOS  one-hot or zero; bit i drives FIFO i `read_enable`.
- `out_data`  out  DATA_WIDTH  registered output word.
- `out_source`  out  SEL_BITS  index of the FIFO that supplied `out_data`.
- `out_valid`  out  1  `out_data` and `out_source` are valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid` & `out_ready`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, WAIT, HOLD.
- IDLE
  - Selects the first i with `fifo_empty[i]`=0, searching from (last_grant+1) mod NUM_FIFOS upward with wrap.
  - Requires `enable`=1 and at least one non-empty FIFO.
  - On selection: current<=i, burst_count<=0, go to READ. Otherwise remain in IDLE.
- READ
  - `read_enable[current]`=1 for exactly this one cycle. The output is a combinational decode of state and current; every other bit stays 0.
  - Unconditionally go to WAIT.
- WAIT
  - The FIFO `q` is now valid.
  - out_data<=`fifo_q` slice [current], out_source<=current, out_valid<=1, go to HOLD.
- HOLD
  - `out_valid`=1, `out_data` and `out_source` stable until accepted.
  - On `out_ready`=1: out_valid<=0 and burst_count<=burst_count+1.
  - Then, if burst_count+1 < BURST_MAX, `enable`=1 and `fifo_empty[current]`=0, go to READ (same FIFO).
  - Otherwise last_grant<=current and go to IDLE.
- `enable` deasserted in READ, WAIT or HOLD: the word in flight completes normally, then the FSM goes to IDLE. No new read is issued.
- The scheduler never asserts `read_enable` to a FIFO whose `fifo_empty`=1 in that cycle.
- last_grant is SEL_BITS wide. The modulo wrap is explicit, because NUM_FIFOS need not be a power of two.
- Arrival or removal of data on other FIFOs during a burst does not pre-empt the current grant.

## Timing
- Reset values:
  - state=IDLE, `read_enable`=0, `out_valid`=0, `out_data`=0, `out_source`=0, `busy`=0.
  - burst_count=0, last_grant=NUM_FIFOS-1, so the first search starts at FIFO 0.
- Reset mid-operation:
  - Aborts immediately.
  - A word already popped from a FIFO but not yet accepted is discarded.
  - `out_valid` drops asynchronously.
- Latency:
  - Cycle 0: IDLE sees a non-empty FIFO.
  - Cycle 1: READ, `read_enable` high.
  - Cycle 2: WAIT.
  - Cycle 3: `out_valid`=1.
- Throughput with `out_ready` held 1: one word per 3 cycles (READ, WAIT, HOLD), plus 1 IDLE cycle per grant change.
- Backpressure: HOLD persists indefinitely while `out_ready`=0. No FIFO is read during that time.
- `out_ready` outside HOLD is ignored.

## Test plan
- Reset, then FIFO 0 holds 0xA0; the others are empty; `out_ready`=1.
  - `read_enable`=4'b0001 for exactly one cycle.
  - `out_valid` high 3 cycles after reset release.
  - `out_data`=0xA0, `out_source`=0.
  - FSM returns to IDLE.
- FIFO 1 holds 6 words, FIFO 2 holds 2 words, BURST_MAX=4, `out_ready`=1.
  - Output order is F1×4, F2×2, F1×2.
  - Source sequence is 1,1,1,1,2,2,1,1.
- All four FIFOs hold 1 word each, `out_ready`=1.
  - Sources are 0,1,2,3.
  - After FIFO 0 refills, the next grant is 0 (wrap from last_grant=3).
- Backpressure: `out_ready`=0 for 10 cycles in HOLD.
  - `out_data` and `out_valid` stay stable.
  - `read_enable`=0 throughout.
  - One cycle after `out_ready`=1, `out_valid`=0.
- `enable` dropped during WAIT with FIFO 0 holding 3 words.
  - That word is delivered.
  - The FSM goes to IDLE; `busy`=0; no further `read_enable`.
  - The remaining 2 words stay in the FIFO.
- Reset asserted during HOLD.
  - Same cycle: `out_valid`=0, `read_enable`=0.
  - After release, the next grant searches from FIFO 0.
